// File: rtl/ram_write_driver.sv
// rtl/ram_write_driver.sv - streams one layer of host weight bytes into the weight RAM
module ram_write_driver #(
   parameter int WEIGHTS_PER_LAYER = 16,
   parameter int NUM_LAYERS        = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] layer,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic [9:0] RAM_address,
   output logic [7:0] RAM_data,
   output logic       RAM_we,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [7:0] checksum
);

   // Per-layer byte budget and layer limit, both at address width.
   localparam logic [9:0] WPL       = 10'(WEIGHTS_PER_LAYER);
   localparam logic [9:0] LAST_IDX  = 10'(WEIGHTS_PER_LAYER - 1);
   localparam logic [9:0] LAYER_LIM = 10'(NUM_LAYERS);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] layer_q;
   logic [9:0] count;
   logic [9:0] base;
   logic       layer_ok;
   logic       accept;

   // A start is honoured only for layers that exist.
   assign layer_ok = ({8'b0, layer} < LAYER_LIM);

   // Bytes arrive unit-major, so base + running count lands at base + unit*4 + input.
   assign base   = {8'b0, layer_q} * WPL;
   assign accept = (state == LOAD) && data_valid;

   // State register; reset drops straight back to IDLE so no write or done can follow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and state-decoded handshake/status outputs.
   always_comb begin
      state_next = state;
      data_ready = 1'b0;
      RAM_we     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start && layer_ok) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            data_ready = 1'b1;
            busy       = 1'b1;
            if (data_valid) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            RAM_we = 1'b1;
            busy   = 1'b1;
            if (count == LAST_IDX) begin
               state_next = DONE;
            end else begin
               state_next = LOAD;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: latch layer on start, capture byte on accept, fold it into the checksum on write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         layer_q     <= 2'd0;
         count       <= 10'd0;
         checksum    <= 8'd0;
         RAM_address <= 10'd0;
         RAM_data    <= 8'd0;
         error       <= 1'b0;
      end else begin
         error <= (state == IDLE) && start && !layer_ok;
         if ((state == IDLE) && start && layer_ok) begin
            layer_q  <= layer;
            count    <= 10'd0;
            checksum <= 8'd0;
         end
         if (accept) begin
            RAM_data    <= data_in;
            RAM_address <= base + count;
         end
         if (state == WRITE) begin
            checksum <= checksum + RAM_data;
            count    <= count + 10'd1;
         end
      end
   end

endmodule

// File: doc/ram_write_driver.md
RAM_WRITE_DRIVER -- requirements
Module: ram_write_driver

Interface
REQ-001 Parameter WEIGHTS_PER_LAYER, default 16: weight bytes per layer (4 units x 4 inputs).
REQ-002 Parameter NUM_LAYERS, default 3: valid layer indices 0..NUM_LAYERS-1.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: request to load one layer; sampled in IDLE only.
REQ-006 Port layer, input, 2: layer to load; latched when start is accepted.
REQ-007 Port data_in, input, 8: weight byte from host.
REQ-008 Port data_valid, input, 1: data_in holds a valid byte.
REQ-009 Port data_ready, output, 1: block can accept a byte this cycle.
REQ-010 Port RAM_address, output, 10: weight RAM write address.
REQ-011 Port RAM_data, output, 8: weight RAM write data.
REQ-012 Port RAM_we, output, 1: weight RAM write enable, one cycle per byte.
REQ-013 Port busy, output, 1: high from accepted start until done.
REQ-014 Port done, output, 1: one-cycle pulse after the last byte of a layer is written.
REQ-015 Port error, output, 1: one-cycle pulse on start with an out-of-range layer.
REQ-016 Port checksum, output, 8: modulo-256 sum of the bytes written for the current or last layer.

Function
REQ-017 States: IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE, start=1, layer<NUM_LAYERS: latch layer, clear byte counter and checksum to 0, set busy=1, go to LOAD next cycle.
REQ-019 IDLE, start=1, layer>=NUM_LAYERS: pulse error for one cycle, stay in IDLE, leave busy=0, leave checksum unchanged.
REQ-020 start in any state other than IDLE: ignored; no error pulse.
REQ-021 LOAD: data_ready=1; byte accepted only on a rising edge where data_valid=1 and data_ready=1.
REQ-022 On accept: register RAM_data=data_in and RAM_address=layer*WEIGHTS_PER_LAYER+count, then go to WRITE.
REQ-023 WRITE: lasts exactly one cycle; RAM_we=1 and data_ready=0; checksum+=RAM_data, wrapping modulo 256; count+=1.
REQ-024 WRITE exit: if count was WEIGHTS_PER_LAYER-1, go to DONE; otherwise go back to LOAD.
REQ-025 Throughput: at most one byte per 2 cycles; RAM_we is never high in two consecutive cycles.
REQ-026 data_valid=0 in LOAD: stay in LOAD indefinitely; no timeout.
REQ-027 DONE: lasts one cycle; done=1 and busy=0 in that cycle; then return to IDLE.
REQ-028 RAM_address and RAM_data hold their last values while RAM_we=0.
REQ-029 checksum holds its value in IDLE until the next accepted start.
REQ-030 Address width: base+count computed at 10 bits; parameters with NUM_LAYERS*WEIGHTS_PER_LAYER>1024 are unsupported.
REQ-031 The address order written matches the reader's ordering: address = base + unit*4 + input, with bytes arriving unit-major.

Reset
REQ-032 reset=0 forces asynchronously: state=IDLE, count=0, data_ready=0, RAM_we=0, busy=0, done=0, error=0, RAM_address=0, RAM_data=0, checksum=0.
REQ-033 Reset asserted mid-layer: no further RAM_we, no done pulse; after release the block waits in IDLE for a new start.
REQ-034 Reset release: the first start is accepted no earlier than the first rising edge with reset=1.

Verification
REQ-035 Load layer 1:
- Stimulus: reset, then start with layer=1; data_valid held high; bytes 0x00..0x0F.
- Required: 16 RAM_we pulses at addresses 16..31 with data 0x00..0x0F.
- Required: done pulses once, 2 cycles after the last accept; checksum=0x78.
REQ-036 Backpressure:
- Stimulus: layer 0; data_valid toggled 1,0,0,1 per byte.
- Required: no write without a prior accept; addresses 0..15 in order; busy stays high throughout.
REQ-037 Invalid layer:
- Stimulus: start with layer=3.
- Required: error=1 for exactly one cycle; busy=0; RAM_we never asserted; checksum unchanged.
REQ-038 Start while busy:
- Stimulus: start with layer=2 pulsed during a layer 0 load.
- Required: the layer 0 load completes at addresses 0..15 only; no writes at 32..47.
REQ-039 Mid-operation reset:
- Stimulus: reset=0 after the 5th write.
- Required: all outputs at reset values immediately.
- Stimulus: new start with layer=2 after release.
- Required: writes at 32..47; checksum restarts from 0.
REQ-040 Checksum wrap:
- Stimulus: 16 bytes of 0xFF.
- Required: checksum=0xF0.
